thread_fetch: RTL and testbench

- Instruction sequencer for one thread; the producer end of the 32-bit instruction word consumed by the thread decoder.
- Holds the 10-bit PC and reads the thread instruction memory, which has 1-cycle synchronous read.
- Presents each word to decode/execute with a valid/ready handshake.
- Resolves jump, setTOS push, pop-return and halt from the word's own control bits.

---
 rtl/thread_fetch.sv | 149 ++++++++++++++
 tb/tb_thread_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_fetch.sv
// Single-thread instruction sequencer: walks the PC through a 1-cycle-latency
// instruction memory and hands each word to decode over a valid/ready handshake.
module thread_fetch #(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ins_out,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [3:0]        stack_cnt,
    output logic              stack_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ins_q, ins_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

    logic              isHalt, isPop, isJump, isPush;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pcInc;
    logic [IDX_W-1:0]  pushIdx, popIdx;
    logic              stackFull, stackEmpty;
    logic [4:0]        cntWide;

    assign isHalt = ins_q[5] & ins_q[4] & ins_q[3];
    assign isPop  = ins_q[5] & ins_q[3] & ~ins_q[4];
    assign isJump = ins_q[5] & ~ins_q[3];
    assign isPush = ~ins_q[5] & ins_q[3] & ins_q[2];
    assign target = ins_q[10 +: ADDR_W];

    assign pcInc      = pc_q + ADDR_W'(1);
    assign pushIdx    = cnt_q[IDX_W-1:0];
    assign popIdx     = pushIdx - IDX_W'(1);
    assign stackFull  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign stackEmpty = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stack_d = stack_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    pc_d    = start_pc;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                ins_d   = imem_rdata;
                state_d = ISSUE;
            end
            ISSUE: begin
                // The word acts only once it has actually been accepted downstream
                if (ins_ready) begin
                    state_d = FETCH;
                    if (isHalt) begin
                        state_d = HALT;
                    end else if (isPop) begin
                        if (!stackEmpty) begin
                            pc_d  = stack_q[popIdx];
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            pc_d  = pcInc;
                            err_d = 1'b1;
                        end
                    end else if (isJump) begin
                        pc_d = target;
                    end else if (isPush) begin
                        pc_d = pcInc;
                        if (!stackFull) begin
                            stack_d[pushIdx] = target;
                            cnt_d            = cnt_q + CNT_W'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        pc_d = pcInc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ins_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    // A full 16-deep stack cannot be shown in 4 bits, so occupancy saturates at 15
    assign cntWide   = 5'(cnt_q);
    assign stack_cnt = (cntWide > 5'd15) ? 4'd15 : cntWide[3:0];

    assign imem_en   = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign ins_out   = ins_q;
    assign ins_valid = (state_q == ISSUE);
    assign pc        = pc_q;
    assign busy      = (state_q == FETCH) || (state_q == WAIT) || (state_q == ISSUE);
    assign halted    = (state_q == HALT);
    assign stack_err = err_q;

endmodule

// File: tb/tb_thread_fetch.sv
// Scoreboard bench for thread_fetch: expected issues are queued when a run is
// started and compared as each word handshakes out of the sequencer.
module tb_thread_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_pc;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ins_out;
    logic        ins_valid;
    logic        ins_ready;
    logic [9:0]  pc;
    logic        busy;
    logic        halted;
    logic [3:0]  stack_cnt;
    logic        stack_err;

    thread_fetch #(.STACK_DEPTH(4), .ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_pc  (start_pc),
        .imem_en   (imem_en),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .ins_out   (ins_out),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .stack_cnt (stack_cnt),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] ins;
        logic [3:0]  cnt;
        logic        err;
    } exp_t;

    exp_t sbQ[$];
    int   issueCyc[$];
    int   cyc = 0;
    int   startCyc;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkWord(input logic [11:0] tag, input logic [9:0] tgt,
                                           input logic [5:0] ctl);
        return {tag, tgt, 4'h0, ctl};
    endfunction

    task automatic expectIssue(input logic [9:0] epc, input logic [31:0] eins,
                               input logic [3:0] ecnt, input logic eerr);
        exp_t e;
        e.pc = epc; e.ins = eins; e.cnt = ecnt; e.err = eerr;
        sbQ.push_back(e);
    endtask

    // Monitor: every accepted word must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && ins_valid && ins_ready) begin
            issueCyc.push_back(cyc);
            if (sbQ.size() == 0) begin
                checkOutput("extraIssue", 32'(ins_valid), 32'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("issuePc", 32'(pc), 32'(e.pc));
                checkOutput("issueIns", ins_out, e.ins);
                checkOutput("issueCnt", 32'(stack_cnt), 32'(e.cnt));
                checkOutput("issueErr", 32'(stack_err), 32'(e.err));
            end
        end
    end

    task automatic applyStimulus(input logic [9:0] spc);
        @(posedge clk); #1;
        start    = 1'b1;
        start_pc = spc;
        startCyc = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic waitHalt(input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        if (!halted) checkOutput("haltTimeout", 32'(halted), 32'd1);
        checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
        sbQ.delete();
    endtask

    task automatic waitValid(input int budget);
        for (int i = 0; i < budget && !ins_valid; i++) @(negedge clk);
        if (!ins_valid) checkOutput("validTimeout", 32'(ins_valid), 32'd1);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    localparam logic [5:0] PLAIN = 6'b000000;
    localparam logic [5:0] HALTC = 6'b111000;
    localparam logic [5:0] POPC  = 6'b101000;
    localparam logic [5:0] JUMPC = 6'b100000;
    localparam logic [5:0] PUSHC = 6'b001100;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        start_pc  = '0;
        ins_ready = 1'b1;
        clearMem();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstImemEn", 32'(imem_en), 32'd0);
        checkOutput("rstImemAddr", 32'(imem_addr), 32'd0);
        checkOutput("rstInsOut", ins_out, 32'd0);
        checkOutput("rstValid", 32'(ins_valid), 32'd0);
        checkOutput("rstPc", 32'(pc), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstHalted", 32'(halted), 32'd0);
        checkOutput("rstCnt", 32'(stack_cnt), 32'd0);
        checkOutput("rstErr", 32'(stack_err), 32'd0);

        // Sequential run with issue timing
        mem[0] = mkWord(12'h0A0, 10'h000, PLAIN);
        mem[1] = mkWord(12'h0A1, 10'h155, PLAIN);
        mem[2] = mkWord(12'h0A2, 10'h2AA, PLAIN);
        mem[3] = mkWord(12'h0A3, 10'h000, HALTC);
        for (int k = 0; k < 4; k++) expectIssue(10'(k), mem[k], 4'd0, 1'b0);
        issueCyc.delete();
        applyStimulus(10'd0);
        waitHalt(40);
        for (int k = 0; k < 4; k++) begin
            if (k < issueCyc.size()) checkOutput("issueCycle", 32'(issueCyc[k] - startCyc), 32'(3 * (k + 1)));
            else checkOutput("issueCount", 32'(issueCyc.size()), 32'd4);
        end
        checkOutput("haltHalted", 32'(halted), 32'd1);
        checkOutput("haltBusy", 32'(busy), 32'd0);
        checkOutput("haltPc", 32'(pc), 32'd3);
        checkOutput("haltValid", 32'(ins_valid), 32'd0);

        // Jump redirect
        clearMem();
        mem[5]     = mkWord(12'h0B5, 10'h200, JUMPC);
        mem[6]     = mkWord(12'h0B6, 10'h000, PLAIN);
        mem[10'h200] = mkWord(12'h0BB, 10'h000, HALTC);
        expectIssue(10'd5, mem[5], 4'd0, 1'b0);
        expectIssue(10'h200, mem[10'h200], 4'd0, 1'b0);
        applyStimulus(10'd5);
        waitHalt(40);

        // Push then pop-return
        clearMem();
        mem[0]     = mkWord(12'h0C0, 10'h010, PUSHC);
        mem[1]     = mkWord(12'h0C1, 10'h000, POPC);
        mem[10'h10] = mkWord(12'h0C2, 10'h000, HALTC);
        expectIssue(10'd0, mem[0], 4'd0, 1'b0);
        expectIssue(10'd1, mem[1], 4'd1, 1'b0);
        expectIssue(10'h10, mem[10'h10], 4'd0, 1'b0);
        applyStimulus(10'd0);
        waitHalt(40);
        checkOutput("loopCnt", 32'(stack_cnt), 32'd0);
        checkOutput("loopErr", 32'(stack_err), 32'd0);

        // Overflow: fifth push dropped, pop returns the fourth target
        clearMem();
        for (int k = 0; k < 5; k++) begin
            mem[10'h20 + k] = mkWord(12'h0D0 + 12'(k), 10'h100 + 10'(k), PUSHC);
            expectIssue(10'h20 + 10'(k), mem[10'h20 + k], 4'(k), 1'b0);
        end
        mem[10'h25]  = mkWord(12'h0D5, 10'h000, POPC);
        mem[10'h103] = mkWord(12'h0D6, 10'h000, HALTC);
        expectIssue(10'h25, mem[10'h25], 4'd4, 1'b1);
        expectIssue(10'h103, mem[10'h103], 4'd3, 1'b1);
        applyStimulus(10'h20);
        waitHalt(80);
        checkOutput("ovfCnt", 32'(stack_cnt), 32'd3);
        checkOutput("ovfErr", 32'(stack_err), 32'd1);

        // Underflow: pop on empty stack falls through; start clears the stale error
        mem[10'h30] = mkWord(12'h0E0, 10'h0FF, POPC);
        mem[10'h31] = mkWord(12'h0E1, 10'h000, HALTC);
        expectIssue(10'h30, mem[10'h30], 4'd0, 1'b0);
        expectIssue(10'h31, mem[10'h31], 4'd0, 1'b1);
        applyStimulus(10'h30);
        waitHalt(40);
        checkOutput("udfErr", 32'(stack_err), 32'd1);
        checkOutput("udfPc", 32'(pc), 32'h31);

        // Backpressure stall and PC wrap
        clearMem();
        mem[1023] = mkWord(12'h0F0, 10'h077, PLAIN);
        mem[0]    = mkWord(12'h0F1, 10'h000, HALTC);
        expectIssue(10'd1023, mem[1023], 4'd0, 1'b0);
        expectIssue(10'd0, mem[0], 4'd0, 1'b0);
        ins_ready = 1'b0;
        applyStimulus(10'd1023);
        waitValid(20);
        checkOutput("startClrErr", 32'(stack_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stallValid", 32'(ins_valid), 32'd1);
            checkOutput("stallIns", ins_out, mem[1023]);
        end
        @(posedge clk); #1 ins_ready = 1'b1;
        waitHalt(40);
        checkOutput("wrapPc", 32'(pc), 32'd0);

        // Reset while stalled in ISSUE; start held alongside reset is ignored
        clearMem();
        mem[10'h40] = mkWord(12'h111, 10'h000, PLAIN);
        mem[10'h41] = mkWord(12'h112, 10'h000, HALTC);
        ins_ready = 1'b0;
        applyStimulus(10'h40);
        waitValid(20);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; start_pc = 10'h40;
        @(posedge clk); #1;
        checkOutput("midRstValid", 32'(ins_valid), 32'd0);
        checkOutput("midRstIns", ins_out, 32'd0);
        checkOutput("midRstPc", 32'(pc), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstHalted", 32'(halted), 32'd0);
        checkOutput("midRstImemEn", 32'(imem_en), 32'd0);
        @(posedge clk); #1;
        checkOutput("rstStartIgnored", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checkOutput("postRstIdle", 32'(busy), 32'd0);
        checkOutput("postRstFetch", 32'(imem_en), 32'd0);
        ins_ready = 1'b1;
        expectIssue(10'h40, mem[10'h40], 4'd0, 1'b0);
        expectIssue(10'h41, mem[10'h41], 4'd0, 1'b0);
        applyStimulus(10'h40);
        waitHalt(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
